// File: rtl/alu_operand_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage_if
//  Description : Decode-to-EX operand bus: source selects, register data,
//                forwarding results and the registered EX-stage operands.
//  Revision    : 1.0  initial release
// ============================================================================
interface alu_operand_stage_if #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
);
    logic            in_valid;
    logic            stall;
    logic            flush;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [1:0]      src_a_sel;
    logic [1:0]      src_b_sel;
    logic            exmem_wen;
    logic            memwb_wen;
    logic [RAW-1:0]  exmem_rd;
    logic [RAW-1:0]  memwb_rd;
    logic [XLEN-1:0] exmem_data;
    logic [XLEN-1:0] memwb_data;
    logic            out_valid;
    logic [XLEN-1:0] alu_in1;
    logic [XLEN-1:0] alu_in2;
    logic [XLEN-1:0] store_data;

    modport master (
        output in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
               pc, imm, src_a_sel, src_b_sel, exmem_wen, memwb_wen,
               exmem_rd, memwb_rd, exmem_data, memwb_data,
        input  out_valid, alu_in1, alu_in2, store_data
    );

    modport slave (
        input  in_valid, stall, flush, rs1_addr, rs2_addr, rs1_data, rs2_data,
               pc, imm, src_a_sel, src_b_sel, exmem_wen, memwb_wen,
               exmem_rd, memwb_rd, exmem_data, memwb_data,
        output out_valid, alu_in1, alu_in2, store_data
    );
endinterface
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : alu_operand_stage
//  Description : ALU operand selection with EX/MEM and MEM/WB forwarding,
//                registered into the EX stage with stall/flush control.
//                Forwarding is built only when ALU_OPERAND_FWD_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
    parameter int XLEN = 32,
    parameter int RAW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    alu_operand_stage_if.slave bus
);

    localparam logic [XLEN-1:0] c_FOUR = XLEN'(4);

    logic [XLEN-1:0] w_rs1Res;
    logic [XLEN-1:0] w_rs2Res;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    logic            r_outValid;
    logic [XLEN-1:0] r_aluIn1;
    logic [XLEN-1:0] r_aluIn2;
    logic [XLEN-1:0] r_storeData;

`ifdef ALU_OPERAND_FWD_EN
    // MEM/WB is applied first so a matching EX/MEM result overrides it.
    always_comb begin
        w_rs1Res = bus.rs1_data;
        if (bus.memwb_wen && (bus.memwb_rd == bus.rs1_addr) && (bus.rs1_addr != '0))
            w_rs1Res = bus.memwb_data;
        if (bus.exmem_wen && (bus.exmem_rd == bus.rs1_addr) && (bus.rs1_addr != '0))
            w_rs1Res = bus.exmem_data;
    end

    always_comb begin
        w_rs2Res = bus.rs2_data;
        if (bus.memwb_wen && (bus.memwb_rd == bus.rs2_addr) && (bus.rs2_addr != '0))
            w_rs2Res = bus.memwb_data;
        if (bus.exmem_wen && (bus.exmem_rd == bus.rs2_addr) && (bus.rs2_addr != '0))
            w_rs2Res = bus.exmem_data;
    end
`else
    logic w_unusedFwd;

    assign w_rs1Res    = bus.rs1_data;
    assign w_rs2Res    = bus.rs2_data;
    assign w_unusedFwd = ^{bus.rs1_addr, bus.rs2_addr, bus.exmem_wen, bus.memwb_wen,
                           bus.exmem_rd, bus.memwb_rd, bus.exmem_data, bus.memwb_data};
`endif

    always_comb begin
        w_op1 = '0;
        case (bus.src_a_sel)
            2'b00:   w_op1 = w_rs1Res;
            2'b01:   w_op1 = bus.pc;
            default: w_op1 = '0;
        endcase
    end

    always_comb begin
        w_op2 = '0;
        case (bus.src_b_sel)
            2'b00:   w_op2 = w_rs2Res;
            2'b01:   w_op2 = bus.imm;
            2'b10:   w_op2 = c_FOUR;
            default: w_op2 = '0;
        endcase
    end

    // Flush only kills the valid bit; the data registers keep their contents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_outValid  <= 1'b0;
            r_aluIn1    <= '0;
            r_aluIn2    <= '0;
            r_storeData <= '0;
        end else if (bus.flush) begin
            r_outValid  <= 1'b0;
        end else if (!bus.stall) begin
            r_outValid <= bus.in_valid;
            if (bus.in_valid) begin
                r_aluIn1    <= w_op1;
                r_aluIn2    <= w_op2;
                r_storeData <= w_rs2Res;
            end
        end
    end

    assign bus.out_valid  = r_outValid;
    assign bus.alu_in1    = r_aluIn1;
    assign bus.alu_in2    = r_aluIn2;
    assign bus.store_data = r_storeData;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_operand_stage
//  Description : Self-checking bench for alu_operand_stage: directed cases
//                with literal expectations plus randomized traffic against a
//                behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

    logic clk;
    logic rst;
    int   nChecks;
    int   nFails;
    logic checkEn;
    logic fwdBuild;

    logic        expValid;
    logic [31:0] expIn1;
    logic [31:0] expIn2;
    logic [31:0] expSd;

    alu_operand_stage_if #(.XLEN(32), .RAW(5)) bus ();

    alu_operand_stage #(.XLEN(32), .RAW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        nChecks++;
        if (act !== req) begin
            nFails++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, req, $time);
        end
    endtask

    // Register value as seen by the consumer after applying the forwarding rules.
    function automatic logic [31:0] resolved(input logic [4:0] a, input logic [31:0] d);
        if (fwdBuild && a != 5'd0) begin
            if (bus.exmem_wen && bus.exmem_rd == a) return bus.exmem_data;
            if (bus.memwb_wen && bus.memwb_rd == a) return bus.memwb_data;
        end
        return d;
    endfunction

    always @(posedge clk) begin
        logic [31:0] srcA [4];
        logic [31:0] srcB [4];
        srcA = '{resolved(bus.rs1_addr, bus.rs1_data), bus.pc, 32'd0, 32'd0};
        srcB = '{resolved(bus.rs2_addr, bus.rs2_data), bus.imm, 32'd4, 32'd0};
        if (rst) begin
            expValid <= 1'b0;
            expIn1   <= 32'd0;
            expIn2   <= 32'd0;
            expSd    <= 32'd0;
        end else if (bus.flush) begin
            expValid <= 1'b0;
        end else if (!bus.stall) begin
            expValid <= bus.in_valid;
            if (bus.in_valid) begin
                expIn1 <= srcA[bus.src_a_sel];
                expIn2 <= srcB[bus.src_b_sel];
                expSd  <= srcB[0];
            end
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            check("model_out_valid", {31'd0, bus.out_valid}, {31'd0, expValid});
            check("model_alu_in1", bus.alu_in1, expIn1);
            check("model_alu_in2", bus.alu_in2, expIn2);
            check("model_store_data", bus.store_data, expSd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs();
        bus.in_valid   = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        bus.rs1_addr   = '0;
        bus.rs2_addr   = '0;
        bus.rs1_data   = '0;
        bus.rs2_data   = '0;
        bus.pc         = '0;
        bus.imm        = '0;
        bus.src_a_sel  = 2'b00;
        bus.src_b_sel  = 2'b00;
        bus.exmem_wen  = 1'b0;
        bus.memwb_wen  = 1'b0;
        bus.exmem_rd   = '0;
        bus.memwb_rd   = '0;
        bus.exmem_data = '0;
        bus.memwb_data = '0;
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        checkEn = 1'b0;
`ifdef ALU_OPERAND_FWD_EN
        fwdBuild = 1'b1;
`else
        fwdBuild = 1'b0;
`endif
        idleInputs();
        rst = 1'b1;
        tick();
        checkEn = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("reset_alu_in1", bus.alu_in1, 32'd0);
        check("reset_alu_in2", bus.alu_in2, 32'd0);
        check("reset_store_data", bus.store_data, 32'd0);

        // PC + 4
        bus.in_valid  = 1'b1;
        bus.src_a_sel = 2'b01;
        bus.pc        = 32'h0000_1000;
        bus.src_b_sel = 2'b10;
        tick();
        check("pc_alu_in1", bus.alu_in1, 32'h0000_1000);
        check("const4_alu_in2", bus.alu_in2, 32'h4);
        check("pc_out_valid", {31'd0, bus.out_valid}, 32'd1);

        // Both stages target rs1=5
        bus.src_a_sel  = 2'b00;
        bus.rs1_addr   = 5'd5;
        bus.rs1_data   = 32'h11;
        bus.exmem_wen  = 1'b1;
        bus.exmem_rd   = 5'd5;
        bus.exmem_data = 32'hAA;
        bus.memwb_wen  = 1'b1;
        bus.memwb_rd   = 5'd5;
        bus.memwb_data = 32'hBB;
        tick();
        check("fwd_exmem_priority", bus.alu_in1, fwdBuild ? 32'hAA : 32'h11);
        bus.exmem_wen = 1'b0;
        tick();
        check("fwd_memwb", bus.alu_in1, fwdBuild ? 32'hBB : 32'h11);

        // x0 never forwarded
        bus.memwb_wen  = 1'b0;
        bus.src_b_sel  = 2'b00;
        bus.rs2_addr   = 5'd0;
        bus.rs2_data   = 32'd0;
        bus.exmem_wen  = 1'b1;
        bus.exmem_rd   = 5'd0;
        bus.exmem_data = 32'hFFFF_FFFF;
        tick();
        check("x0_alu_in2", bus.alu_in2, 32'd0);
        check("x0_store_data", bus.store_data, 32'd0);

        // Immediate operand vs store data
        bus.src_b_sel  = 2'b01;
        bus.imm        = 32'hFFFF_FFF0;
        bus.rs2_addr   = 5'd3;
        bus.rs2_data   = 32'h1234;
        bus.exmem_rd   = 5'd3;
        bus.exmem_data = 32'h1234;
        tick();
        check("imm_alu_in2", bus.alu_in2, 32'hFFFF_FFF0);
        check("imm_store_data", bus.store_data, 32'h1234);

        // Stall holds everything
        bus.exmem_wen = 1'b0;
        bus.src_a_sel = 2'b01;
        bus.pc        = 32'h2000;
        bus.imm       = 32'h55;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.stall = 1'b1;
            bus.pc    = 32'h3000 + 32'(i);
            bus.imm   = 32'h77 + 32'(i);
            tick();
            check("stall_alu_in1", bus.alu_in1, 32'h2000);
            check("stall_alu_in2", bus.alu_in2, 32'h55);
            check("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
        end
        bus.flush = 1'b1;
        tick();
        check("flush_stall_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("flush_holds_alu_in1", bus.alu_in1, 32'h2000);

        // Reset during a stall with a valid instruction held
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        tick();
        bus.stall = 1'b1;
        rst       = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_stall_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_stall_alu_in1", bus.alu_in1, 32'd0);
        check("rst_stall_alu_in2", bus.alu_in2, 32'd0);
        check("rst_stall_store_data", bus.store_data, 32'd0);
        bus.stall = 1'b0;

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 49) == 0);
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.flush      = ($urandom_range(0, 7) == 0);
            bus.rs1_addr   = 5'($urandom_range(0, 7));
            bus.rs2_addr   = 5'($urandom_range(0, 7));
            bus.rs1_data   = $urandom;
            bus.rs2_data   = $urandom;
            bus.pc         = $urandom;
            bus.imm        = $urandom;
            bus.src_a_sel  = 2'($urandom_range(0, 3));
            bus.src_b_sel  = 2'($urandom_range(0, 3));
            bus.exmem_wen  = 1'($urandom_range(0, 1));
            bus.memwb_wen  = 1'($urandom_range(0, 1));
            bus.exmem_rd   = 5'($urandom_range(0, 7));
            bus.memwb_rd   = 5'($urandom_range(0, 7));
            bus.exmem_data = $urandom;
            bus.memwb_data = $urandom;
            tick();
        end
        rst = 1'b0;
        idleInputs();
        tick();
        @(negedge clk);
        #1;
        checkEn = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Parametrised ALU operand selection and ID/EX pipeline stage. Builds ALU operand 1 from register, PC or zero, and operand 2 from register, immediate or constant 4, with EX/MEM and MEM/WB result forwarding. Registers both operands plus store data into the EX stage with stall/flush control. Sits between decode/register-file read and the ALU.

## Interface
- `XLEN`, 32, datapath width in bits
- `RAW`, 5, register address width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in_valid`  in  1  decode stage presents a valid instruction
- `stall`  in  1  hold EX-stage registers
- `flush`  in  1  replace captured instruction with a bubble
- `rs1_addr`, `rs2_addr`  in  RAW  source register numbers
- `rs1_data`, `rs2_data`  in  XLEN  register-file read data
- `pc`  in  XLEN  instruction address
- `imm`  in  XLEN  sign-extended immediate
- `src_a_sel`  in  2  00 rs1, 01 pc, 10 zero, 11 zero (reserved)
- `src_b_sel`  in  2  00 rs2, 01 imm, 10 constant 4, 11 zero (reserved)
- `exmem_wen`, `memwb_wen`  in  1  writeback enables of the later stages
- `exmem_rd`, `memwb_rd`  in  RAW  destination registers of the later stages
- `exmem_data`, `memwb_data`  in  XLEN  results of the later stages
- `out_valid`  out  1  EX stage holds a valid instruction
- `alu_in1`, `alu_in2`  out  XLEN  registered ALU operands
- `store_data`  out  XLEN  registered forwarded rs2 value, independent of `src_b_sel`

## Operation
- Resolved rs value (per source, combinational): if `exmem_wen` and `exmem_rd`==rsN and rsN!=0, use `exmem_data`. Otherwise, if `memwb_wen` and `memwb_rd`==rsN and rsN!=0, use `memwb_data`. Otherwise use `rsN_data`.
- EX/MEM takes priority over MEM/WB. Register 0 is never forwarded.
- Operand 1 is muxed from resolved rs1 / `pc` / 0 according to `src_a_sel`.
- Operand 2 is muxed from resolved rs2 / `imm` / 4 / 0 according to `src_b_sel`. The constant 4 is zero-extended to XLEN.
- `store_data` is always resolved rs2.
- Register update priority per clock edge:
  1. `rst`: all outputs cleared.
  2. `flush`: `out_valid` goes to 0; data registers hold.
  3. `stall`: all registers hold.
  4. Otherwise: `out_valid` takes `in_valid`. Data registers load only when `in_valid`=1 and otherwise hold.
- No arithmetic beyond the comparisons. All values pass through at XLEN bits unchanged.

## Timing
- Reset values: `out_valid`=0, `alu_in1`=0, `alu_in2`=0, `store_data`=0.
- Latency is 1 cycle from inputs sampled at edge N to outputs valid after edge N.
- Forwarding inputs are sampled at the same edge as `rs*_data`. The producer result must therefore be present in the cycle the consumer is in decode.
- Stall with `in_valid`=1: the upstream instruction is not consumed. Upstream must hold it. Outputs stay constant for every stalled cycle.
- flush and stall together: flush wins, so `out_valid` goes to 0 on that edge.
- rst asserted mid-stream: all outputs clear on the next edge regardless of `stall` or `flush`.
- Both forwarding stages matching the same register: EX/MEM data is used.

## Configuration
- `ALU_OPERAND_FWD_EN` defined: forwarding logic is present as described.
- `ALU_OPERAND_FWD_EN` undefined:
  - resolved rsN is `rsN_data` directly;
  - all `exmem_*` and `memwb_*` inputs are ignored;
  - the hazard unit must stall instead.
- Ports are identical in both builds.

## Test plan
- Reset, then `in_valid`=1, `src_a_sel`=01, `pc`=0x0000_1000, `src_b_sel`=10 -> next cycle `alu_in1`=0x0000_1000, `alu_in2`=0x4, `out_valid`=1.
- rs1=5, `rs1_data`=0x11; `exmem_wen`=1, `exmem_rd`=5, `exmem_data`=0xAA; `memwb_wen`=1, `memwb_rd`=5, `memwb_data`=0xBB -> `alu_in1`=0xAA. With `exmem_wen`=0 -> `alu_in1`=0xBB.
- rs2=0, `exmem_wen`=1, `exmem_rd`=0, `exmem_data`=0xFFFF_FFFF, `rs2_data`=0 -> `alu_in2`=0 and `store_data`=0.
- `src_b_sel`=01, `imm`=0xFFFF_FFF0, rs2 forwarded value 0x1234 -> `alu_in2`=0xFFFF_FFF0, `store_data`=0x1234.
- Valid instruction captured, then `stall`=1 for 3 cycles with changing inputs -> outputs unchanged. Then `stall`=1 and `flush`=1 together -> `out_valid`=0.
- Apply `rst` during a stall with `out_valid`=1 -> all outputs 0 after the next edge. Repeat the forwarding test with `ALU_OPERAND_FWD_EN` undefined -> `alu_in1`=0x11.
